hyp_leg_solver: RTL
===================

Name: hyp_leg_solver

Overview:
Inverse companion to the hypotenuse unit. Given hypotenuse c and one leg a, it returns the other leg b = floor(sqrt(c^2 - a^2)). The block is multi-cycle and avoids multipliers: shift-add squaring followed by a restoring bitwise square root. It sits behind a valid/ready handshake, so it can be placed between the pin-level wrapper and downstream logic.

Parameters:
- W, 8, operand and result width; intermediate squares are 2*W bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  global enable; low stalls the FSM and all datapath registers
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- c_in  in  W  hypotenuse
- a_in  in  W  known leg
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- leg_out  out  W  computed leg
- err_out  out  1  a_in > c_in; leg_out forced to 0

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after release (IDLE); out_valid=0; leg_out=0; err_out=0; all internal registers 0.
- FSM states and transitions:
  - IDLE -> SQ on accept; IDLE -> DONE directly on accept when a_in > c_in.
  - SQ (W cycles) -> DIFF (1 cycle) -> ROOT (W cycles) -> DONE.
  - DONE -> IDLE on out_valid & out_ready.
- Accept: happens on a clock edge where in_valid & in_ready & ena. c_in and a_in are captured on that edge. in_ready = (state==IDLE).
- SQ: two parallel shift-add squarers, one LSB-first bit per cycle. No `*` operator anywhere.
- DIFF: d = c^2 - a^2, 2W bits unsigned; never negative because the error case has already been filtered.
- ROOT: restoring integer sqrt, one result bit per cycle, MSB first (bit W-1 down to 0). Divide operator not used.
- Latency:
  - Normal path: out_valid rises 2W+1 = 17 edges after the accept edge.
  - Error path: out_valid rises on the first edge after accept, with err_out=1 and leg_out=0.
- Output hold: leg_out, err_out and out_valid are registered and held stable while out_valid & !out_ready. No new request is accepted until the result is taken. After out_ready, in_ready returns one cycle later (no same-cycle turnaround).
- ena=0: state, counters and outputs freeze; handshake events are ignored that cycle.
- Boundary cases:
  - c==a -> leg 0, err 0.
  - a==0 -> leg = c exactly.
  - c=255, a=0 -> d=65025, leg=255.
  - The result never exceeds 2^W-1.
- Reset mid-operation: the computation is aborted, the FSM returns to IDLE and no stale out_valid appears.

Optional Feature:
- Macro HYP_LEG_ROUND_EN.
  - Defined: result rounds to nearest; add 1 when remainder (d - r^2) > r. Max result is still 255, so no overflow.
  - Undefined: floor. Latency is identical either way; rounding is folded into the last ROOT cycle.

Decomposition:
- Package hyp_pkg:
  - state enum (IDLE, SQ, DIFF, ROOT, DONE)
  - W default
  - SQW = 2*W
  - cycle-count constants SQ_CYCLES = W, ROOT_CYCLES = W
- One sub-module, isqrt_iter:
  - interface: start, 2W-bit operand, W-bit root, remainder, done
  - iterative restoring sqrt, instantiated by hyp_leg_solver
- The squarers are inline shift-add registers in the top block.

Test Plan:
- c=5, a=3 -> leg 4, err 0; out_valid exactly 17 edges after accept; in_ready low throughout.
- c=255, a=0 -> 255. c=10, a=10 -> 0. c=13, a=12 -> 5.
- c=255, a=1 (d=65024) -> 254 without the macro; 255 with HYP_LEG_ROUND_EN.
- c=5, a=7 -> err 1, leg 0, out_valid 1 edge after accept.
- Backpressure: out_ready low for 5 cycles holds leg_out/err_out stable and keeps in_ready=0. ena low for 3 cycles mid-ROOT extends latency by exactly 3.
- Reset asserted during ROOT -> all outputs 0 immediately; in_ready=1 after release; the next request (c=5, a=4 -> 3) is correct.

Source files
------------

// File: rtl/hyp_leg_solver_pkg.sv
// Shared types and constants for the hypotenuse-leg solver.
package hyp_pkg;

  localparam int HYP_W       = 8;
  localparam int HYP_SQW     = 2 * HYP_W;
  localparam int SQ_CYCLES   = HYP_W;
  localparam int ROOT_CYCLES = HYP_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    DIFF = 3'd2,
    ROOT = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/hyp_leg_solver_isqrt_iter.sv
// Iterative restoring integer square root, one result bit per cycle, MSB
// first. root/rem show the outcome of the iteration in progress so the
// caller can capture the final result on the same edge that done marks.
module isqrt_iter
  import hyp_pkg::*;
#(
  parameter int W = HYP_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           start,
  input  logic [2*W-1:0] operand,
  output logic [W-1:0]   root,
  output logic [W+1:0]   rem,
  output logic           done
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] opnd;
  logic [W+1:0]   rem_acc;
  logic [W-1:0]   root_acc;
  logic [CW-1:0]  cnt;
  logic           busy;
  logic [W+1:0]   rem_sh;
  logic [W+1:0]   trial;
  logic           ge;

  // One restoring step: bring down two operand bits, try subtracting 4r+1.
  always_comb begin
    rem_sh = (rem_acc << 2) | (W+2)'(opnd[2*W-1 -: 2]);
    trial  = {root_acc, 2'b01};
    ge     = (rem_sh >= trial);
    rem    = ge ? (rem_sh - trial) : rem_sh;
    root   = (root_acc << 1) | W'(ge);
    done   = busy && (cnt == CW'(W-1));
  end

  // Load on start, then iterate W times while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd     <= '0;
      rem_acc  <= '0;
      root_acc <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else if (ena) begin
      if (start) begin
        opnd     <= operand;
        rem_acc  <= '0;
        root_acc <= '0;
        cnt      <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        opnd     <= opnd << 2;
        rem_acc  <= rem;
        root_acc <= root;
        cnt      <= cnt + CW'(1);
        busy     <= !done;
      end
    end
  end

endmodule

// File: rtl/hyp_leg_solver.sv
// Other-leg solver: leg = floor(sqrt(c^2 - a^2)) via shift-add squaring and
// a restoring square root, behind a valid/ready handshake.
// Define HYP_LEG_ROUND_EN to round the result to nearest instead of floor;
// the rounding is folded into the last ROOT cycle so latency is unchanged.
module hyp_leg_solver
  import hyp_pkg::*;
#(
  parameter int W = HYP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] a_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] leg_out,
  output logic         err_out
);

  localparam int SQW = 2 * W;
  localparam int CW  = $clog2(W);
`ifdef HYP_LEG_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  state_t         state, state_nxt;
  logic [SQW-1:0] mc_c, mc_a, acc_c, acc_a;
  logic [W-1:0]   mp_c, mp_a;
  logic [CW-1:0]  sq_cnt;
  logic           accept, is_err;
  logic [SQW-1:0] diff;
  logic [W-1:0]   root;
  logic [W+1:0]   rem;
  logic           root_done;
  logic [W-1:0]   leg_res;

  // Held low while reset is asserted, then follows IDLE.
  assign in_ready = rst_n && (state == IDLE);
  assign accept   = in_valid && in_ready && ena;
  assign is_err   = (a_in > c_in);
  assign diff     = acc_c - acc_a;
  // Round up when the remainder d - r^2 exceeds r; r=2^W-1 always has rem 0.
  assign leg_res  = root + W'(ROUND_EN && (rem > (W+2)'(root)));

  isqrt_iter #(.W(W)) u_isqrt (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (state == DIFF),
    .operand (diff),
    .root    (root),
    .rem     (rem),
    .done    (root_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; everything holds while ena is low.
  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        IDLE:    if (accept) state_nxt = is_err ? DONE : SQ;
        SQ:      if (sq_cnt == CW'(W-1)) state_nxt = DIFF;
        DIFF:    state_nxt = ROOT;
        ROOT:    if (root_done) state_nxt = DONE;
        DONE:    if (out_valid && out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Squarers, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_c      <= '0;
      mc_a      <= '0;
      acc_c     <= '0;
      acc_a     <= '0;
      mp_c      <= '0;
      mp_a      <= '0;
      sq_cnt    <= '0;
      out_valid <= 1'b0;
      leg_out   <= '0;
      err_out   <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: if (accept) begin
          mc_c    <= SQW'(c_in);
          mc_a    <= SQW'(a_in);
          mp_c    <= c_in;
          mp_a    <= a_in;
          acc_c   <= '0;
          acc_a   <= '0;
          sq_cnt  <= '0;
          err_out <= is_err;
          leg_out <= '0;
        end
        SQ: begin
          acc_c  <= acc_c + (mp_c[0] ? mc_c : '0);
          acc_a  <= acc_a + (mp_a[0] ? mc_a : '0);
          mc_c   <= mc_c << 1;
          mc_a   <= mc_a << 1;
          mp_c   <= mp_c >> 1;
          mp_a   <= mp_a >> 1;
          sq_cnt <= sq_cnt + CW'(1);
        end
        ROOT: if (root_done) begin
          leg_out   <= leg_res;
          out_valid <= 1'b1;
        end
        // Error path enters DONE with out_valid low; it rises one edge later.
        DONE: out_valid <= !(out_valid && out_ready);
        default: ;
      endcase
    end
  end

endmodule
